// File: rtl/window_3x3_builder.sv
// 3x3 neighbourhood window generator for a raster RGB444 stream.
// Two line buffers feed a sliding 3-column window; only interior centres are emitted.
module window_3x3_builder #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned PIX_W      = 12,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  pixelIn,
  input  logic              pixelValid,
  input  logic              frameStart,
  output logic [PIX_W-1:0]  outPixel_lu,
  output logic [PIX_W-1:0]  outPixel_lm,
  output logic [PIX_W-1:0]  outPixel_ld,
  output logic [PIX_W-1:0]  outPixel_mu,
  output logic [PIX_W-1:0]  outPixel_mm,
  output logic [PIX_W-1:0]  outPixel_md,
  output logic [PIX_W-1:0]  outPixel_ru,
  output logic [PIX_W-1:0]  outPixel_rm,
  output logic [PIX_W-1:0]  outPixel_rd,
  output logic [ADDR_W-1:0] xAddr,
  output logic [ADDR_W-1:0] yAddr,
  output logic              windowValid,
  output logic              frameDone
);

  localparam int unsigned      COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

  // line_a holds row y-1, line_b holds row y-2 (not reset; masked by the col/row>=2 rule)
  logic [PIX_W-1:0] line_a [IMG_WIDTH];
  logic [PIX_W-1:0] line_b [IMG_WIDTH];

  logic [ADDR_W-1:0] col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0] col_cur, row_cur;
  logic [COL_W-1:0]  ram_idx;
  logic [PIX_W-1:0]  rd_a, rd_b;
  logic              emit;

  // Column vectors are indexed [0]=u, [1]=m, [2]=d; the left column falls out on each shift.
  logic [2:0][PIX_W-1:0]      new_col;
  logic [2:0][PIX_W-1:0]      col_m_q, col_m_d, col_r_q, col_r_d;
  // Output window indexed [column l/m/r][row u/m/d].
  logic [2:0][2:0][PIX_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0]          x_q, x_d, y_q, y_d;
  logic                       valid_q, valid_d, done_q, done_d;

  // Next-state: counters, window shift and output capture for the accepted beat.
  always_comb begin
    col_cur  = frameStart ? '0 : col_q;
    row_cur  = frameStart ? '0 : row_q;
    ram_idx  = col_cur[COL_W-1:0];
    rd_a     = line_a[ram_idx];
    rd_b     = line_b[ram_idx];
    new_col  = {pixelIn, rd_a, rd_b};
    emit     = pixelValid && (col_cur >= TWO) && (row_cur >= TWO);

    col_d    = col_q;
    row_d    = row_q;
    col_m_d  = col_m_q;
    col_r_d  = col_r_q;
    out_d    = out_q;
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    if (pixelValid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ONE;
      end else begin
        col_d = col_cur + ONE;
        row_d = row_cur;
      end
      col_m_d = col_r_q;
      col_r_d = new_col;
    end

    if (emit) begin
      out_d[0] = col_m_q;
      out_d[1] = col_r_q;
      out_d[2] = new_col;
      x_d      = col_cur - ONE;
      y_d      = row_cur - ONE;
      valid_d  = 1'b1;
      done_d   = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      col_m_q <= '0;
      col_r_q <= '0;
      out_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      col_m_q <= col_m_d;
      col_r_q <= col_r_d;
      out_q   <= out_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Read-before-write line buffer update: row y-1 ages into row y-2.
  always_ff @(posedge clk25) begin
    if (pixelValid) begin
      line_b[ram_idx] <= rd_a;
      line_a[ram_idx] <= pixelIn;
    end
  end

  assign outPixel_lu = out_q[0][0];
  assign outPixel_lm = out_q[0][1];
  assign outPixel_ld = out_q[0][2];
  assign outPixel_mu = out_q[1][0];
  assign outPixel_mm = out_q[1][1];
  assign outPixel_md = out_q[1][2];
  assign outPixel_ru = out_q[2][0];
  assign outPixel_rm = out_q[2][1];
  assign outPixel_rd = out_q[2][2];
  assign xAddr       = x_q;
  assign yAddr       = y_q;
  assign windowValid = valid_q;
  assign frameDone   = done_q;

endmodule
